// File: rtl/ntt_pkg.sv
// Shared types and default constants for the NTT multiply-accumulate PE.
package ntt_pkg;

    localparam int NTT_W = 12;
    localparam int NTT_Q = 3329;

    // Beat mode; the encoding 3 is reserved and behaves like MODE_ADD.
    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_NSUB = 2'd1,
        MODE_ACC  = 2'd2
    } mode_e;

    // Accumulation sequencer state.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/mod_mul_reduce.sv
// Combinational (a*b) mod Q; both operands are reduced mod Q first so any
// W-bit input yields an exact result in [0, Q-1].
module mod_mul_reduce #(
    parameter int W = 12,
    parameter int Q = 3329
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r
);

    localparam logic [W-1:0]   QW = W'(Q);
    localparam logic [2*W-1:0] Q2 = (2*W)'(Q);

    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [2*W-1:0] prod;

    // Pre-reduce, full-width multiply, final reduction.
    always_comb begin
        a_r  = a % QW;
        b_r  = b % QW;
        prod = {{W{1'b0}}, a_r} * {{W{1'b0}}, b_r};
        r    = W'(prod % Q2);
    end

endmodule

// File: rtl/ntt_mac_pe.sv
// Systolic modular MAC cell over Z_Q: 2-stage pipeline with horizontal
// operand forwarding, ADD / NSUB / ACC modes and a global stall (en).
// Optional build macro NTT_MAC_PE_RANGE_CHECK_EN adds the sticky err_out flag.
module ntt_mac_pe
    import ntt_pkg::*;
#(
    parameter int W       = NTT_W,
    parameter int Q       = NTT_Q,
    parameter int ACC_LEN = 4,
    parameter int CNT_W   = $clog2(ACC_LEN)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    input  logic [1:0]   mode,
    input  logic [W-1:0] horz,
    input  logic [W-1:0] vert,
    input  logic [W-1:0] offset,
    output logic [W-1:0] horz_out,
    output logic         horz_valid_out,
    output logic [W-1:0] diag_out,
    output logic         diag_valid_out,
`ifdef NTT_MAC_PE_RANGE_CHECK_EN
    output logic         err_out,
`endif
    output logic         acc_busy
);

    localparam logic [W-1:0] QW = W'(Q);
    localparam logic [W:0]   Q1 = (W+1)'(Q);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    // Stage 1 registers
    logic [W-1:0] h_q, h_d;
    logic         v1_q, v1_d;
    logic [1:0]   mode_q, mode_d;
    logic [W-1:0] off_q, off_d;
    logic [W-1:0] p_q, p_d;

    // Stage 2 / accumulator registers
    logic [W-1:0]   diag_q, diag_d;
    logic           dvld_q, dvld_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e         state_q, state_d;
    logic           abort;

    logic [W-1:0] p_w;
    logic [W-1:0] off_red;

    // Product term and offset reduction share the same reducer; offset*1 mod Q
    // brings an out-of-range offset back into the field.
    mod_mul_reduce #(.W(W), .Q(Q)) u_mul (
        .a (horz),
        .b (vert),
        .r (p_w)
    );

    mod_mul_reduce #(.W(W), .Q(Q)) u_off (
        .a (offset),
        .b (W'(1)),
        .r (off_red)
    );

    // Stage 1 next-state: capture the beat when enabled, otherwise hold.
    always_comb begin
        h_d    = h_q;
        v1_d   = v1_q;
        mode_d = mode_q;
        off_d  = off_q;
        p_d    = p_q;
        if (en) begin
            h_d    = horz;
            v1_d   = in_valid;
            mode_d = mode;
            off_d  = off_red;
            p_d    = p_w;
        end
    end

    logic [W-1:0] add_op;
    logic [W:0]   sum;
    logic [W-1:0] sum_m;
    logic [W:0]   diff;
    logic [W-1:0] diff_m;

    // Modular add/sub: W+1-bit raw result with one conditional correction.
    // While collecting, the running accumulator replaces the offset operand.
    always_comb begin
        add_op = ((state_q == COLLECT) && (mode_q == MODE_ACC)) ? acc_q : off_q;
        sum    = {1'b0, add_op} + {1'b0, p_q};
        sum_m  = W'((sum >= Q1) ? (sum - Q1) : sum);
        diff   = {1'b0, off_q} - {1'b0, p_q};
        if (off_q < p_q) begin
            diff = diff + Q1;
        end
        diff_m = W'(diff);
    end

    // Stage 2 next-state: result register, valid pulse and ACC sequencer.
    always_comb begin
        diag_d  = diag_q;
        dvld_d  = dvld_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        abort   = 1'b0;
        if (en) begin
            dvld_d = 1'b0;
            if (v1_q) begin
                if (mode_q == MODE_ACC) begin
                    if (state_q == IDLE) begin
                        acc_d   = sum_m;
                        cnt_d   = CNT_W'(1);
                        state_d = COLLECT;
                    end else if (cnt_q == CNT_LAST) begin
                        diag_d  = sum_m;
                        dvld_d  = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d = sum_m;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Any other valid beat ends a partial ACC sequence.
                    abort   = (state_q == COLLECT);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                    diag_d  = (mode_q == MODE_NSUB) ? diff_m : sum_m;
                    dvld_d  = 1'b1;
                end
            end
        end
    end

`ifdef NTT_MAC_PE_RANGE_CHECK_EN
    logic err_q, err_d;

    // Sticky range/abort flag; only reset clears it.
    always_comb begin
        err_d = err_q;
        if (en) begin
            if (in_valid && ((horz >= QW) || (vert >= QW) || (offset >= QW))) begin
                err_d = 1'b1;
            end
            if (abort) begin
                err_d = 1'b1;
            end
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_out = err_q;
`endif

    // Pipeline, accumulator and state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q     <= '0;
            v1_q    <= 1'b0;
            mode_q  <= '0;
            off_q   <= '0;
            p_q     <= '0;
            diag_q  <= '0;
            dvld_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            h_q     <= h_d;
            v1_q    <= v1_d;
            mode_q  <= mode_d;
            off_q   <= off_d;
            p_q     <= p_d;
            diag_q  <= diag_d;
            dvld_q  <= dvld_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign horz_out       = h_q;
    assign horz_valid_out = v1_q;
    assign diag_out       = diag_q;
    assign diag_valid_out = dvld_q;
    assign acc_busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_ntt_mac_pe.sv
// Directed self-checking bench for ntt_mac_pe (W=12, Q=3329, ACC_LEN=4).
module tb_ntt_mac_pe;

    logic        clk;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [1:0]  mode;
    logic [11:0] horz;
    logic [11:0] vert;
    logic [11:0] offset;
    logic [11:0] horz_out;
    logic        horz_valid_out;
    logic [11:0] diag_out;
    logic        diag_valid_out;
    logic        acc_busy;
`ifdef NTT_MAC_PE_RANGE_CHECK_EN
    logic        err_out;
`endif

    int total = 0;
    int bad   = 0;

    ntt_mac_pe #(.W(12), .Q(3329), .ACC_LEN(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .in_valid       (in_valid),
        .mode           (mode),
        .horz           (horz),
        .vert           (vert),
        .offset         (offset),
        .horz_out       (horz_out),
        .horz_valid_out (horz_valid_out),
        .diag_out       (diag_out),
        .diag_valid_out (diag_valid_out),
`ifdef NTT_MAC_PE_RANGE_CHECK_EN
        .err_out        (err_out),
`endif
        .acc_busy       (acc_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [1:0] m, input logic [11:0] h,
                       input logic [11:0] vv, input logic [11:0] o);
        in_valid = v;
        mode     = m;
        horz     = h;
        vert     = vv;
        offset   = o;
    endtask

    task automatic test_reset();
        #3;
        total++; if (horz_out !== 12'd0) begin bad++; $display("FAIL reset_horz_out got=%0d exp=0", horz_out); end
        total++; if (horz_valid_out !== 1'b0) begin bad++; $display("FAIL reset_hvalid got=%0b exp=0", horz_valid_out); end
        total++; if (diag_out !== 12'd0) begin bad++; $display("FAIL reset_diag got=%0d exp=0", diag_out); end
        total++; if (diag_valid_out !== 1'b0) begin bad++; $display("FAIL reset_dvalid got=%0b exp=0", diag_valid_out); end
        total++; if (acc_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", acc_busy); end
`ifdef NTT_MAC_PE_RANGE_CHECK_EN
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err_out); end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_add();
        drv(1, 2'd0, 12'd3000, 12'd2, 12'd1000);
        step();
        total++; if (horz_out !== 12'd3000) begin bad++; $display("FAIL add_horz_out got=%0d exp=3000", horz_out); end
        total++; if (horz_valid_out !== 1'b1) begin bad++; $display("FAIL add_hvalid got=%0b exp=1", horz_valid_out); end
        drv(0, 2'd0, 12'd0, 12'd0, 12'd0);
        step();
        total++; if (diag_out !== 12'd342) begin bad++; $display("FAIL add_diag got=%0d exp=342", diag_out); end
        total++; if (diag_valid_out !== 1'b1) begin bad++; $display("FAIL add_dvalid got=%0b exp=1", diag_valid_out); end
        step();
        total++; if (diag_valid_out !== 1'b0) begin bad++; $display("FAIL add_dvalid_drop got=%0b exp=0", diag_valid_out); end
        // reserved mode 3 behaves as ADD: 10*20+5
        drv(1, 2'd3, 12'd10, 12'd20, 12'd5);
        step();
        drv(0, 2'd0, 12'd0, 12'd0, 12'd0);
        step();
        total++; if (diag_out !== 12'd205) begin bad++; $display("FAIL add_mode3 got=%0d exp=205", diag_out); end
        // out-of-range operands: 3330=1, 3329=0 -> 1*5+0
        drv(1, 2'd0, 12'd3330, 12'd5, 12'd3329);
        step();
        drv(0, 2'd0, 12'd0, 12'd0, 12'd0);
        step();
        total++; if (diag_out !== 12'd5) begin bad++; $display("FAIL add_oor got=%0d exp=5", diag_out); end
    endtask

    task automatic test_nsub();
        drv(1, 2'd1, 12'd3000, 12'd2, 12'd1000);
        step();
        drv(1, 2'd1, 12'd1, 12'd1, 12'd0);
        step();
        total++; if (diag_out !== 12'd1658) begin bad++; $display("FAIL nsub_wrap got=%0d exp=1658", diag_out); end
        drv(1, 2'd1, 12'd3, 12'd4, 12'd100);
        step();
        total++; if (diag_out !== 12'd3328) begin bad++; $display("FAIL nsub_edge got=%0d exp=3328", diag_out); end
        drv(0, 2'd0, 12'd0, 12'd0, 12'd0);
        step();
        total++; if (diag_out !== 12'd88) begin bad++; $display("FAIL nsub_nowrap got=%0d exp=88", diag_out); end
        total++; if (diag_valid_out !== 1'b1) begin bad++; $display("FAIL nsub_dvalid got=%0b exp=1", diag_valid_out); end
        step();
    endtask

    task automatic test_acc();
        drv(1, 2'd2, 12'd1, 12'd1, 12'd10);
        step();
        drv(1, 2'd2, 12'd2, 12'd2, 12'd0);
        step();
        total++; if (acc_busy !== 1'b1) begin bad++; $display("FAIL acc_busy_b1 got=%0b exp=1", acc_busy); end
        total++; if (diag_valid_out !== 1'b0) begin bad++; $display("FAIL acc_novalid_b1 got=%0b exp=0", diag_valid_out); end
        drv(0, 2'd2, 12'd0, 12'd0, 12'd0);
        step();
        drv(1, 2'd2, 12'd3, 12'd3, 12'd0);
        step();
        total++; if (acc_busy !== 1'b1) begin bad++; $display("FAIL acc_busy_gap got=%0b exp=1", acc_busy); end
        drv(1, 2'd2, 12'd4, 12'd4, 12'd0);
        step();
        total++; if (diag_valid_out !== 1'b0) begin bad++; $display("FAIL acc_novalid_b3 got=%0b exp=0", diag_valid_out); end
        total++; if (horz_out !== 12'd4) begin bad++; $display("FAIL acc_horz_fwd got=%0d exp=4", horz_out); end
        drv(0, 2'd0, 12'd0, 12'd0, 12'd0);
        step();
        total++; if (diag_out !== 12'd40) begin bad++; $display("FAIL acc_result got=%0d exp=40", diag_out); end
        total++; if (diag_valid_out !== 1'b1) begin bad++; $display("FAIL acc_dvalid got=%0b exp=1", diag_valid_out); end
        total++; if (acc_busy !== 1'b0) begin bad++; $display("FAIL acc_busy_end got=%0b exp=0", acc_busy); end
        step();
        total++; if (diag_valid_out !== 1'b0) begin bad++; $display("FAIL acc_single_pulse got=%0b exp=0", diag_valid_out); end
    endtask

    task automatic test_abort();
        drv(1, 2'd2, 12'd1, 12'd1, 12'd10);
        step();
        drv(1, 2'd2, 12'd2, 12'd2, 12'd0);
        step();
        drv(1, 2'd0, 12'd5, 12'd5, 12'd0);
        step();
        total++; if (acc_busy !== 1'b1) begin bad++; $display("FAIL abort_busy got=%0b exp=1", acc_busy); end
        total++; if (diag_valid_out !== 1'b0) begin bad++; $display("FAIL abort_novalid got=%0b exp=0", diag_valid_out); end
        drv(0, 2'd0, 12'd0, 12'd0, 12'd0);
        step();
        total++; if (diag_out !== 12'd25) begin bad++; $display("FAIL abort_diag got=%0d exp=25", diag_out); end
        total++; if (diag_valid_out !== 1'b1) begin bad++; $display("FAIL abort_dvalid got=%0b exp=1", diag_valid_out); end
        total++; if (acc_busy !== 1'b0) begin bad++; $display("FAIL abort_busy_drop got=%0b exp=0", acc_busy); end
`ifdef NTT_MAC_PE_RANGE_CHECK_EN
        total++; if (err_out !== 1'b1) begin bad++; $display("FAIL abort_err got=%0b exp=1", err_out); end
`endif
        step();
    endtask

    task automatic test_stall();
        drv(1, 2'd0, 12'd3000, 12'd2, 12'd1000);
        step();
        drv(1, 2'd1, 12'd1, 12'd1, 12'd0);
        step();
        en = 1'b0;
        drv(1, 2'd0, 12'd77, 12'd88, 12'd99);
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (diag_out !== 12'd342) begin bad++; $display("FAIL stall_diag[%0d] got=%0d exp=342", i, diag_out); end
            total++; if (diag_valid_out !== 1'b1) begin bad++; $display("FAIL stall_dvalid[%0d] got=%0b exp=1", i, diag_valid_out); end
            total++; if (horz_out !== 12'd1) begin bad++; $display("FAIL stall_horz[%0d] got=%0d exp=1", i, horz_out); end
        end
        en = 1'b1;
        drv(0, 2'd0, 12'd0, 12'd0, 12'd0);
        step();
        total++; if (diag_out !== 12'd3328) begin bad++; $display("FAIL stall_resume got=%0d exp=3328", diag_out); end
        total++; if (diag_valid_out !== 1'b1) begin bad++; $display("FAIL stall_resume_v got=%0b exp=1", diag_valid_out); end
        step();
        total++; if (diag_valid_out !== 1'b0) begin bad++; $display("FAIL stall_drop got=%0b exp=0", diag_valid_out); end
    endtask

    task automatic test_reset_mid();
        drv(1, 2'd2, 12'd1, 12'd1, 12'd10);
        step();
        drv(1, 2'd2, 12'd2, 12'd2, 12'd0);
        step();
        #2;
        rst = 1'b0;
        #1;
        total++; if (horz_out !== 12'd0) begin bad++; $display("FAIL rmid_horz got=%0d exp=0", horz_out); end
        total++; if (horz_valid_out !== 1'b0) begin bad++; $display("FAIL rmid_hvalid got=%0b exp=0", horz_valid_out); end
        total++; if (acc_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b exp=0", acc_busy); end
        total++; if (diag_out !== 12'd0) begin bad++; $display("FAIL rmid_diag got=%0d exp=0", diag_out); end
`ifdef NTT_MAC_PE_RANGE_CHECK_EN
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL rmid_err got=%0b exp=0", err_out); end
`endif
        drv(0, 2'd0, 12'd0, 12'd0, 12'd0);
        @(negedge clk);
        rst = 1'b1;
        drv(1, 2'd2, 12'd2, 12'd3, 12'd1);
        step();
        drv(1, 2'd2, 12'd1, 12'd1, 12'd0);
        step();
        step();
        step();
        drv(0, 2'd0, 12'd0, 12'd0, 12'd0);
        step();
        total++; if (diag_out !== 12'd10) begin bad++; $display("FAIL rmid_fresh got=%0d exp=10", diag_out); end
        total++; if (diag_valid_out !== 1'b1) begin bad++; $display("FAIL rmid_fresh_v got=%0b exp=1", diag_valid_out); end
`ifdef NTT_MAC_PE_RANGE_CHECK_EN
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL err_clean got=%0b exp=0", err_out); end
        drv(1, 2'd0, 12'd3329, 12'd1, 12'd0);
        step();
        drv(0, 2'd0, 12'd0, 12'd0, 12'd0);
        total++; if (err_out !== 1'b1) begin bad++; $display("FAIL err_range got=%0b exp=1", err_out); end
        step();
`endif
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        drv(0, 2'd0, 12'd0, 12'd0, 12'd0);
        test_reset();
        test_add();
        test_nsub();
        test_acc();
        test_abort();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ntt_mac_pe.md
Name: ntt_mac_pe

Overview:
Parametrised successor of the systolic polynomial-multiplier PE cell. It performs a pipelined modular multiply-accumulate over Z_Q with valid tracking and a global stall. Three modes are supported: cyclic add, negacyclic subtract, and local K-term accumulation. Cells tile into a 2-D systolic array inside the NTT/poly-mult datapath, forwarding horizontal operands and emitting reduced diagonal partial sums.

Parameters:
W, 12, operand/result width in bits
Q, 3329, modulus; Q < 2**W, Q odd
ACC_LEN, 4, beats per accumulation in ACC mode; >= 2
CNT_W, $clog2(ACC_LEN), accumulation counter width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
en  in  1  pipeline enable; 0 freezes all registers
in_valid  in  1  input beat qualifier
mode  in  2  0=ADD, 1=NSUB, 2=ACC, 3=reserved (treated as ADD)
horz  in  W  horizontal operand, forwarded
vert  in  W  vertical (stationary/coefficient) operand
offset  in  W  incoming partial sum
horz_out  out  W  horz delayed 1 cycle
horz_valid_out  out  1  in_valid delayed 1 cycle
diag_out  out  W  reduced result
diag_valid_out  out  1  result qualifier
acc_busy  out  1  high while an ACC sequence is partially collected

Behaviour:
- Reset (rst=0, async): all outputs, pipeline registers, accumulator and counter go to 0 immediately. Operation resumes on the first clk edge after rst deasserts; in-flight beats are lost.
- en=0: every register holds its value, including outputs, valids and counter. Inputs are ignored.
- Stage 1 (edge 1): register horz, in_valid, mode and offset. Register p = (horz*vert) mod Q. horz_out and horz_valid_out are taken from this stage, so their latency is 1.
- Stage 2 (edge 2): compute and register diag_out, with diag_valid_out = stage-1 valid. Latency is 2.
  - ADD: (offset + p) mod Q.
  - NSUB: (offset - p) mod Q; if offset < p, add Q.
- Reduction is exact for operands < Q. All arithmetic uses a 2W-bit product and a W+1-bit sum/difference before conditional correction. Results are always in [0, Q-1].
- Operands >= Q: the inputs are first reduced mod Q at stage 1, so the result is still correct.
- ACC state machine (states IDLE, COLLECT), driven only by valid stage-1 beats with mode=2:
  - IDLE + ACC beat: acc = (offset + p) mod Q, cnt = 1, go to COLLECT, acc_busy = 1. No diag_valid_out.
  - COLLECT + ACC beat with cnt < ACC_LEN-1: acc = (acc + p) mod Q, cnt++. offset is ignored.
  - COLLECT + ACC beat with cnt = ACC_LEN-1: diag_out = (acc + p) mod Q, diag_valid_out = 1, acc = 0, cnt = 0, go to IDLE.
  - Invalid beats leave acc and cnt unchanged (gaps are allowed).
  - A non-ACC valid beat in COLLECT aborts the sequence: acc and cnt are cleared, go to IDLE, and the beat is processed normally in its own mode.
- acc_busy is registered and equals (state == COLLECT).
- diag_valid_out pulses for exactly one en-cycle per completed result.
- In ACC mode horz forwarding is unchanged (latency 1).

Optional Feature:
NTT_MAC_PE_RANGE_CHECK_EN
- Defined: adds output port err_out (1 bit). It is a sticky flag, set on any valid beat with horz >= Q, vert >= Q, offset >= Q, or an ACC abort. It is cleared only by rst. Data behaviour is unchanged.
- Undefined: no port and no checking logic.

Decomposition:
- Package ntt_pkg holds:
  - mode enum (MODE_ADD=0, MODE_NSUB=1, MODE_ACC=2)
  - state enum (IDLE, COLLECT)
  - default Q=3329 and W=12 constants
- Sub-module mod_mul_reduce (parameters W, Q): combinational (a*b) mod Q with input pre-reduction, instantiated in stage 1.
- Modular add/sub is inline logic.

Test Plan:
- ADD: horz=3000, vert=2, offset=1000, in_valid=1 -> horz_out=3000 after 1 cycle; diag_out=342 with diag_valid_out=1 after 2 cycles.
- NSUB: same operands, mode=1 -> diag_out=1658; offset=0, horz=1, vert=1 -> 3328.
- ACC, ACC_LEN=4: beats (1,1,off=10), (2,2), gap cycle, (3,3), (4,4) -> acc_busy high from beat 1 to the final beat. A single diag_valid_out pulse with diag_out=40 appears 2 cycles after beat 4.
- ACC abort: 2 ACC beats, then an ADD beat (5,5,off=0) -> diag_out=25 with no ACC result; acc_busy drops.
- en=0 held for 3 cycles mid-stream -> outputs frozen; resuming yields the identical result sequence, shifted by 3 cycles.
- rst pulled low mid-ACC without a clk edge -> all outputs 0 immediately. After release a fresh ACC sequence yields the correct sum. With the macro defined, horz=3329 sets err_out.
